data_ram_access_unit: RTL

Initiator-side access unit for the processor's data RAM. It accepts load, store and block-copy commands from the execute stage over a valid/ready handshake and drives the RAM's address, write-data and write-enable lines. It captures the RAM's registered read data and returns load results. It sits between the pipeline's memory stage and the data RAM and is the only master on the RAM port.

---
 rtl/data_ram_access_unit_if.sv | 32 +++
 rtl/data_ram_access_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_ram_access_unit_if.sv
// Command and RAM-port bundle for the data RAM access unit.
// The slave view is the unit itself; master is the complementary view.
interface data_ram_access_unit_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic [1:0]            command;
   logic                  commandValid;
   logic                  commandReady;
   logic [ADDR_WIDTH-1:0] baseAddress;
   logic [ADDR_WIDTH-1:0] targetAddress;
   logic [ADDR_WIDTH-1:0] length;
   logic [DATA_WIDTH-1:0] storeData;
   logic [DATA_WIDTH-1:0] loadData;
   logic                  loadValid;
   logic                  done;
   logic                  fault;
   logic [ADDR_WIDTH-1:0] ramAddress;
   logic [DATA_WIDTH-1:0] ramDataC;
   logic                  ramWriteEnable;
   logic [DATA_WIDTH-1:0] ramReadData;

   modport slave (
      input  command, commandValid, baseAddress, targetAddress, length, storeData, ramReadData,
      output commandReady, loadData, loadValid, done, fault, ramAddress, ramDataC, ramWriteEnable
   );

   modport master (
      output command, commandValid, baseAddress, targetAddress, length, storeData, ramReadData,
      input  commandReady, loadData, loadValid, done, fault, ramAddress, ramDataC, ramWriteEnable
   );
endinterface

// File: rtl/data_ram_access_unit.sv
// Sole master of the data RAM port: executes load, store and block-copy commands
// from the execute stage, with range checking at accept time.
module data_ram_access_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DEPTH      = 301
) (
   input logic                   clock,
   input logic                   reset,
   data_ram_access_unit_if.slave bus
);
   typedef enum logic [2:0] {
      StIdle, StLoadReq, StLoadCap, StStore, StCopyRd, StCopyCap, StCopyWr, StFinish
   } state_e;

   localparam logic [1:0]            CmdLoad  = 2'b00;
   localparam logic [1:0]            CmdStore = 2'b01;
   localparam logic [1:0]            CmdCopy  = 2'b10;
   localparam logic [ADDR_WIDTH:0]   DepthLim = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   OneW     = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] OneA     = ADDR_WIDTH'(1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, target_q, target_d, len_q, len_d, idx_q, idx_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic                  prime_q, prime_d;
   logic                  ready_q, ready_d, we_q, we_d;
   logic                  lvalid_q, lvalid_d, done_q, done_d, fault_q, fault_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, ldata_q, ldata_d;
   logic                  accept, bad;
   logic [ADDR_WIDTH:0]   src_end, dst_end;

   assign accept = bus.commandValid & ready_q;

   // Range check on the raw command fields, one bit wider so end addresses cannot wrap.
   always_comb begin
      src_end = {1'b0, bus.baseAddress} + {1'b0, bus.length} - OneW;
      dst_end = {1'b0, bus.targetAddress} + {1'b0, bus.length} - OneW;
      case (bus.command)
         CmdLoad, CmdStore: bad = ({1'b0, bus.baseAddress} >= DepthLim);
         CmdCopy:           bad = (bus.length != '0) && ((src_end >= DepthLim) ||
                                                          (dst_end >= DepthLim));
         default:           bad = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         base_q   <= '0;
         target_q <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         buf_q    <= '0;
         prime_q  <= 1'b0;
         ready_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         ldata_q  <= '0;
         lvalid_q <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         target_q <= target_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         buf_q    <= buf_d;
         prime_q  <= prime_d;
         ready_q  <= ready_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         ldata_q  <= ldata_d;
         lvalid_q <= lvalid_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      target_d = target_q;
      len_d    = len_q;
      idx_d    = idx_q;
      buf_d    = buf_q;
      prime_d  = prime_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               base_d   = bus.baseAddress;
               target_d = bus.targetAddress;
               len_d    = bus.length;
               idx_d    = '0;
               prime_d  = 1'b1;
               if (bad) begin
                  state_d = StFinish;
               end else begin
                  case (bus.command)
                     CmdLoad:  state_d = StLoadReq;
                     CmdStore: state_d = StStore;
                     default:  state_d = (bus.length == '0) ? StFinish : StCopyRd;
                  endcase
               end
            end
         end
         // The first read of a command holds its address for an extra cycle.
         StLoadReq: begin
            if (prime_q) prime_d = 1'b0;
            else         state_d = StLoadCap;
         end
         StLoadCap: state_d = StFinish;
         StStore:   state_d = StIdle;
         StCopyRd: begin
            if (prime_q) prime_d = 1'b0;
            else         state_d = StCopyCap;
         end
         StCopyCap: begin
            buf_d   = bus.ramReadData;
            state_d = StCopyWr;
         end
         StCopyWr: begin
            if (idx_q == len_q - OneA) begin
               state_d = StFinish;
            end else begin
               idx_d   = idx_q + OneA;
               state_d = StCopyRd;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output registers are loaded from the next state so they line up with it.
   always_comb begin
      ready_d  = (state_d == StIdle);
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      ldata_d  = ldata_q;
      lvalid_d = 1'b0;
      done_d   = 1'b0;
      fault_d  = 1'b0;
      if (state_q == StLoadCap) ldata_d = bus.ramReadData;
      case (state_d)
         StLoadReq, StCopyRd: addr_d = base_d + idx_d;
         StStore: begin
            addr_d  = base_d;
            wdata_d = bus.storeData;
            we_d    = 1'b1;
            done_d  = 1'b1;
         end
         StCopyWr: begin
            addr_d  = target_d + idx_d;
            wdata_d = buf_d;
            we_d    = 1'b1;
         end
         StFinish: begin
            fault_d  = (state_q == StIdle) & bad;
            lvalid_d = (state_q == StLoadCap);
            done_d   = ~fault_d & ~lvalid_d;
         end
         default: ;
      endcase
   end

   assign bus.commandReady   = ready_q;
   assign bus.ramAddress     = addr_q;
   assign bus.ramDataC       = wdata_q;
   assign bus.ramWriteEnable = we_q;
   assign bus.loadData       = ldata_q;
   assign bus.loadValid      = lvalid_q;
   assign bus.done           = done_q;
   assign bus.fault          = fault_q;
endmodule
